load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001: Parameter ADDRESS_WIDTH, default 16: byte-address width presented to the data RAM.
REQ-002: clock  input  1  the single clock; all state updates on its rising edge.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: start  input  1  command strobe, sampled only in IDLE.
REQ-005: is_load  input  1  the command is a load (LB/LH/LW/LBU/LHU/FLW).
REQ-006: is_store  input  1  the command is a store (SB/SH/SW/FSW).
REQ-007: funct3  input  3  size code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-008: address  input  32  effective byte address from the ALU.
REQ-009: store_data  input  32  store source; the data sits in the low bits.
REQ-010: busy  output  1  high whenever the state is not IDLE.
REQ-011: done  output  1  one-cycle completion pulse.
REQ-012: misaligned  output  1  error flag, valid only while done is high.
REQ-013: load_data  output  32  extended load result; holds its value until the next load completes.
REQ-014: ram_address  output  ADDRESS_WIDTH  byte address to the data RAM (the RAM uses bits [15:2]).
REQ-015: ram_write  output  1  data RAM write enable.
REQ-016: ram_write_data  output  32  full word to write.
REQ-017: ram_read_data  input  32  RAM read data, valid one cycle after ram_address is presented.

Function
REQ-018: States are IDLE, READ, MERGE, CAPTURE, WRITE and DONE.
REQ-019: In IDLE with start=1, the unit SHALL register address[ADDRESS_WIDTH-1:0], funct3, store_data and the operation, then move on.
- address[31:ADDRESS_WIDTH] is ignored, so addresses wrap.
REQ-020: A command is illegal when any of the following holds. An illegal command SHALL go IDLE->DONE with misaligned=1, no RAM write, and load_data unchanged.
- is_load == is_store.
- funct3 is not a listed code, or is_store with funct3 at 100 or 101.
- A half access with addr[0]=1.
- A word access with addr[1:0]!=00.
REQ-021: Load sequence SHALL be IDLE->READ->CAPTURE->DONE, so done is high 3 cycles after the start cycle.
REQ-022: Word-store sequence SHALL be IDLE->WRITE->DONE, so done is high 2 cycles after start.
REQ-023: Sub-word store sequence SHALL be IDLE->READ->MERGE->WRITE->DONE, so done is high 4 cycles after start.
- This is a read-modify-write.
REQ-024: In READ, ram_address SHALL equal the registered address, and ram_write SHALL be 0.
REQ-025: In CAPTURE, the unit SHALL select bytes from ram_read_data and register load_data.
- Byte n occupies bits [8n+7:8n] (little-endian).
- Byte lane is addr[1:0]; half lane is addr[1].
- funct3 000/001 sign-extend; 100/101 zero-extend.
REQ-026: In MERGE, the unit SHALL register ram_read_data with only the addressed byte or half replaced by store_data[7:0] or [15:0].
REQ-027: ram_write SHALL be 1 only in WRITE, for exactly one cycle per store.
- ram_write_data is the merged word, or store_data for SW.
- ram_address is the registered address.
REQ-028: done SHALL be 1 only in DONE; DONE always returns to IDLE on the next edge.
REQ-029: start SHALL be ignored while busy=1, including in DONE; a new command is accepted at the earliest one cycle after done.
REQ-030: The unit SHALL hold at most one outstanding command and SHALL never issue a RAM write for a load.

Reset
REQ-031: While reset=1, the unit SHALL immediately hold:
- state=IDLE;
- busy=0, done=0, misaligned=0, ram_write=0;
- load_data=0, ram_address=0, ram_write_data=0.
REQ-032: Reset asserted in any state SHALL abort the command: no write issued and no done pulse.
REQ-033: The first start sampled after reset deasserts SHALL be accepted normally.

Verification
REQ-034: Load sequence.
- Setup: RAM[0x10]=0x8899AABB.
- LW at 0x10, start at T0 -> done at T3, load_data=0x8899AABB, misaligned=0, ram_write never 1.
REQ-035: Extension and lanes, same word.
- LB at 0x13 -> 0xFFFFFF88.
- LBU at 0x13 -> 0x00000088.
- LH at 0x12 -> 0xFFFF8899.
- LHU at 0x10 -> 0x0000AABB.
REQ-036: Stores.
- SB of 0x000000CC at 0x11 over 0x8899AABB -> single write of 0x8899CCBB in T3, done at T4.
- SW of 0x12345678 at 0x20 -> write in T1, done at T2.
REQ-037: Illegal commands.
- SW at 0x22 -> done at T1 with misaligned=1, no write.
- LH at 0x11 -> done at T1 with misaligned=1, load_data unchanged.
REQ-038: Reset mid-operation.
- Reset pulsed while SH is in MERGE -> ram_write stays 0, memory unchanged, outputs at their reset values.
- A following LW completes normally.
REQ-039: Busy rejection.
- A second start during an in-flight load (cycles T1-T3) is ignored, and exactly one done pulse occurs.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a single-port data RAM.
// A load, a word store, or a sub-word read-modify-write store runs as a
// short FSM sequence. Illegal or misaligned commands finish at once with an
// error flag and never touch the RAM.
//
// Handshake: start is sampled only while the unit is idle (busy=0); once
// accepted, the command owns the unit until done pulses for exactly one
// cycle. Any start seen while busy=1, including the done cycle, is dropped.
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     is_load,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [31:0]              address,
    input  logic [31:0]              store_data,
    output logic                     busy,
    output logic                     done,
    output logic                     misaligned,
    output logic [31:0]              load_data,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic                     ram_write,
    output logic [31:0]              ram_write_data,
    input  logic [31:0]              ram_read_data,
    output logic [2:0]               debug_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        MERGE   = 3'd2,
        CAPTURE = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state, state_next;

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [2:0]               funct3_q;
    logic                     load_q;
    logic                     err_q;
    logic [31:0]              wdata_q;
    logic [31:0]              load_data_q;

    // Upper address bits are dropped on purpose so addresses wrap.
    logic unused_address_hi;
    assign unused_address_hi = ^address[31:ADDRESS_WIDTH];

    // Decode size and legality of the incoming command.
    logic is_byte, is_half, is_word, code_bad, illegal;
    always_comb begin
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        code_bad = 1'b0;
        case (funct3)
            3'b000, 3'b100: is_byte = 1'b1;
            3'b001, 3'b101: is_half = 1'b1;
            3'b010:         is_word = 1'b1;
            default:        code_bad = 1'b1;
        endcase
        illegal = (is_load == is_store)
                || code_bad
                || (is_store && funct3[2])
                || (is_half && address[0])
                || (is_word && (address[1:0] != 2'b00));
    end

    // Lane selection and sign/zero extension for loads.
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;
    always_comb begin
        sel_byte = ram_read_data[8*addr_q[1:0] +: 8];
        sel_half = addr_q[1] ? ram_read_data[31:16] : ram_read_data[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_ext = {24'd0, sel_byte};
            3'b101:  load_ext = {16'd0, sel_half};
            default: load_ext = ram_read_data;
        endcase
    end

    // Replace only the addressed byte or half of the word just read.
    logic [31:0] merged;
    always_comb begin
        merged = ram_read_data;
        if (funct3_q[0]) begin
            if (addr_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
        end else begin
            merged[8*addr_q[1:0] +: 8] = wdata_q[7:0];
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic for the command sequences.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (illegal)                    state_next = DONE;
                    else if (is_load)               state_next = READ;
                    else if (funct3 == 3'b010)      state_next = WRITE;
                    else                            state_next = READ;
                end
            end
            READ:    state_next = load_q ? CAPTURE : MERGE;
            CAPTURE: state_next = DONE;
            MERGE:   state_next = WRITE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command registers, merged write word and held load result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            funct3_q    <= 3'd0;
            load_q      <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= 32'd0;
            load_data_q <= 32'd0;
        end else begin
            if (state == IDLE && start) begin
                addr_q   <= address[ADDRESS_WIDTH-1:0];
                funct3_q <= funct3;
                load_q   <= is_load;
                err_q    <= illegal;
                wdata_q  <= store_data;
            end
            if (state == MERGE)   wdata_q     <= merged;
            if (state == CAPTURE) load_data_q <= load_ext;
        end
    end

    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign misaligned     = (state == DONE) && err_q;
    assign ram_write      = (state == WRITE);
    assign ram_address    = addr_q;
    assign ram_write_data = wdata_q;
    assign load_data      = load_data_q;
    assign debug_state    = state;

endmodule
